// File: rtl/tri_span_gen_if.sv
// Handshake bundle between the triangle span generator, its requester and the span drawer.
interface tri_span_gen_if #(
    parameter int COORD_WIDTH = 16
);
    logic                          start;
    logic signed [COORD_WIDTH-1:0] x0, y0, x1, y1, x2, y2;
    logic                          span_busy_in;
    logic                          span_start;
    logic signed [COORD_WIDTH-1:0] span_y, span_xl, span_xr;
    logic                          busy;
    logic                          done;

    modport slave (
        input  start, x0, y0, x1, y1, x2, y2, span_busy_in,
        output span_start, span_y, span_xl, span_xr, busy, done
    );

    modport master (
        output start, x0, y0, x1, y1, x2, y2, span_busy_in,
        input  span_start, span_y, span_xl, span_xr, busy, done
    );
endinterface

// File: rtl/tri_span_gen.sv
// Scan-converts a triangle into horizontal spans, one row at a time, using
// divider-free error-accumulation DDA on the long and short edges.
module tri_span_gen #(
    parameter int COORD_WIDTH = 16,
    parameter int FB_WIDTH    = 320,
    parameter int FB_HEIGHT   = 180
) (
    input  logic          clk_in,
    input  logic          rst_in,
    tri_span_gen_if.slave bus
);
    localparam int CW = COORD_WIDTH;
    localparam int EW = 2 * COORD_WIDTH + 1;
    localparam logic signed [EW-1:0] FB_W = EW'(FB_WIDTH);
    localparam logic signed [EW-1:0] FB_H = EW'(FB_HEIGHT);

    typedef enum logic [2:0] {
        S_IDLE, S_SORT, S_SETUP, S_STEP, S_EMIT, S_WAIT1, S_WAIT, S_FIN
    } state_t;

    state_t                r_state, w_nextState;
    logic            [1:0] r_sortCnt;
    logic signed  [CW-1:0] r_vx [3];
    logic signed  [CW-1:0] r_vy [3];
    logic signed  [CW-1:0] r_row, r_xL, r_xS;
    logic signed  [EW-1:0] r_errL, r_errS, r_dxL, r_dyL, r_dxS, r_dyS;
    logic signed  [CW-1:0] r_spanY, r_spanXl, r_spanXr;

    logic                  w_upL, w_dnL, w_upS, w_dnS, w_stepping;
    logic                  w_rowVisible, w_spanVisible, w_lastRow, w_advance;
    logic signed  [CW-1:0] w_xMin, w_xMax, w_min01, w_max01, w_min3, w_max3;
    logic signed  [EW-1:0] w_dx12, w_dy12;

    // An edge with dy == 0 never needs correcting; that also covers the flat triangle.
    assign w_upL = (r_dyL != '0) && (r_errL >= r_dyL);
    assign w_dnL = (r_dyL != '0) && (r_errL <= -r_dyL);
    assign w_upS = (r_dyS != '0) && (r_errS >= r_dyS);
    assign w_dnS = (r_dyS != '0) && (r_errS <= -r_dyS);
    assign w_stepping = w_upL || w_dnL || w_upS || w_dnS;

    assign w_xMin = (r_xS < r_xL) ? r_xS : r_xL;
    assign w_xMax = (r_xS < r_xL) ? r_xL : r_xS;
    assign w_min01 = (r_vx[1] < r_vx[0]) ? r_vx[1] : r_vx[0];
    assign w_max01 = (r_vx[1] < r_vx[0]) ? r_vx[0] : r_vx[1];
    assign w_min3 = (r_vx[2] < w_min01) ? r_vx[2] : w_min01;
    assign w_max3 = (r_vx[2] > w_max01) ? r_vx[2] : w_max01;
    assign w_dx12 = EW'(r_vx[2]) - EW'(r_vx[1]);
    assign w_dy12 = EW'(r_vy[2]) - EW'(r_vy[1]);

    assign w_rowVisible  = !r_row[CW-1] && (EW'(r_row) < FB_H);
    assign w_spanVisible = (EW'(w_xMin) < FB_W) && !w_xMax[CW-1];
    assign w_lastRow     = (r_row == r_vy[2]);

    assign bus.span_start = (r_state == S_WAIT1);
    assign bus.busy       = (r_state != S_IDLE) && (r_state != S_FIN);
    assign bus.done       = (r_state == S_FIN);
    assign bus.span_y     = r_spanY;
    assign bus.span_xl    = r_spanXl;
    assign bus.span_xr    = r_spanXr;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= S_IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        w_advance   = 1'b0;
        case (r_state)
            S_IDLE:  if (bus.start) w_nextState = S_SORT;
            S_SORT:  if (r_sortCnt == 2'd2) w_nextState = S_SETUP;
            S_SETUP: w_nextState = S_STEP;
            S_STEP:  if (!w_stepping) w_nextState = S_EMIT;
            S_EMIT: begin
                if (w_rowVisible && w_spanVisible) w_nextState = S_WAIT1;
                else if (w_lastRow)                w_nextState = S_FIN;
                else begin
                    w_nextState = S_STEP;
                    w_advance   = 1'b1;
                end
            end
            // The drawer has not registered span_start yet, so its busy is meaningless here.
            S_WAIT1: w_nextState = S_WAIT;
            S_WAIT: begin
                if (!bus.span_busy_in) begin
                    if (w_lastRow) w_nextState = S_FIN;
                    else begin
                        w_nextState = S_STEP;
                        w_advance   = 1'b1;
                    end
                end
            end
            S_FIN:   w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_sortCnt <= '0;
            for (int i = 0; i < 3; i++) begin
                r_vx[i] <= '0;
                r_vy[i] <= '0;
            end
            r_row    <= '0;
            r_xL     <= '0;
            r_xS     <= '0;
            r_errL   <= '0;
            r_errS   <= '0;
            r_dxL    <= '0;
            r_dyL    <= '0;
            r_dxS    <= '0;
            r_dyS    <= '0;
            r_spanY  <= '0;
            r_spanXl <= '0;
            r_spanXr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_vx[0] <= bus.x0;  r_vy[0] <= bus.y0;
                        r_vx[1] <= bus.x1;  r_vy[1] <= bus.y1;
                        r_vx[2] <= bus.x2;  r_vy[2] <= bus.y2;
                        r_sortCnt <= '0;
                    end
                end
                // Three strict-less compare/swaps form a stable sort, so equal rows keep input order.
                S_SORT: begin
                    r_sortCnt <= r_sortCnt + 2'd1;
                    if (r_sortCnt == 2'd1) begin
                        if (r_vy[2] < r_vy[1]) begin
                            r_vx[1] <= r_vx[2];  r_vx[2] <= r_vx[1];
                            r_vy[1] <= r_vy[2];  r_vy[2] <= r_vy[1];
                        end
                    end else if (r_vy[1] < r_vy[0]) begin
                        r_vx[0] <= r_vx[1];  r_vx[1] <= r_vx[0];
                        r_vy[0] <= r_vy[1];  r_vy[1] <= r_vy[0];
                    end
                end
                S_SETUP: begin
                    r_row  <= r_vy[0];
                    r_errL <= '0;
                    r_errS <= '0;
                    if (r_vy[0] == r_vy[2]) begin
                        r_xL  <= w_min3;
                        r_xS  <= w_max3;
                        r_dxL <= '0;  r_dyL <= '0;
                        r_dxS <= '0;  r_dyS <= '0;
                    end else begin
                        r_xL  <= r_vx[0];
                        r_dxL <= EW'(r_vx[2]) - EW'(r_vx[0]);
                        r_dyL <= EW'(r_vy[2]) - EW'(r_vy[0]);
                        if (r_vy[0] == r_vy[1]) begin
                            r_xS  <= r_vx[1];
                            r_dxS <= w_dx12;
                            r_dyS <= w_dy12;
                        end else begin
                            r_xS  <= r_vx[0];
                            r_dxS <= EW'(r_vx[1]) - EW'(r_vx[0]);
                            r_dyS <= EW'(r_vy[1]) - EW'(r_vy[0]);
                        end
                    end
                end
                S_STEP: begin
                    if (w_upL) begin
                        r_xL <= r_xL + CW'(1);  r_errL <= r_errL - r_dyL;
                    end else if (w_dnL) begin
                        r_xL <= r_xL - CW'(1);  r_errL <= r_errL + r_dyL;
                    end
                    if (w_upS) begin
                        r_xS <= r_xS + CW'(1);  r_errS <= r_errS - r_dyS;
                    end else if (w_dnS) begin
                        r_xS <= r_xS - CW'(1);  r_errS <= r_errS + r_dyS;
                    end
                end
                S_EMIT: begin
                    if (w_rowVisible && w_spanVisible) begin
                        r_spanY  <= r_row;
                        r_spanXl <= w_xMin;
                        r_spanXr <= w_xMax;
                    end
                end
                default: ;
            endcase

            // Entering row y1 hands the short edge over from v0->v1 to v1->v2.
            if (w_advance) begin
                r_row  <= r_row + CW'(1);
                r_errL <= r_errL + r_dxL;
                if (r_row + CW'(1) == r_vy[1]) begin
                    r_xS   <= r_vx[1];
                    r_errS <= '0;
                    r_dxS  <= w_dx12;
                    r_dyS  <= w_dy12;
                end else begin
                    r_errS <= r_errS + r_dxS;
                end
            end
        end
    end
endmodule

// File: doc/tri_span_gen.md
TRI_SPAN_GEN -- requirements
Module: tri_span_gen

Interface
REQ-001 SHALL have parameter COORD_WIDTH, default 16, signed coordinate width.
REQ-002 SHALL have parameter FB_WIDTH, default 320, framebuffer columns.
REQ-003 SHALL have parameter FB_HEIGHT, default 180, framebuffer rows.
REQ-004 clk_in  input  1  sole clock, all logic on rising edge.
REQ-005 rst_in  input  1  reset, asynchronous and active-high.
REQ-006 start  input  1  one-cycle request to rasterize the triangle on x0..y2.
REQ-007 x0,y0,x1,y1,x2,y2  input  COORD_WIDTH each, signed  vertices, sampled only on an accepted start.
REQ-008 span_busy_in  input  1  busy from the downstream 1-D span drawer.
REQ-009 span_start  output  1  one-cycle span request to the span drawer.
REQ-010 span_y  output  COORD_WIDTH, signed  row of the current span.
REQ-011 span_xl, span_xr  output  COORD_WIDTH, signed  span endpoints; span_xl <= span_xr.
REQ-012 busy  output  1  high from accepted start until the done pulse.
REQ-013 done  output  1  one-cycle pulse when the last span has completed.

Function
REQ-014 SHALL use the FSM IDLE -> SORT -> SETUP -> STEP -> EMIT -> WAIT1 -> WAIT -> (STEP | FIN) -> IDLE.
REQ-015 IDLE: start accepted only in IDLE; start in any other state SHALL be ignored; acceptance latches the vertices and sets busy.
REQ-016 SORT: SHALL order the vertices by y ascending (v0.y <= v1.y <= v2.y) over at most 3 cycles, ties keeping input order.
REQ-017 Edge x at row y SHALL be xa + trunc((y-ya)*(xb-xa)/(yb-ya)), truncated toward zero, computed by error-accumulation DDA (no divider).
REQ-018 Long edge is v0->v2; the short edge is v0->v1 for y0 <= y < y1 and v1->v2 for y1 <= y <= y2.
REQ-019 When y0 == y1, the v0->v1 edge SHALL be skipped and rasterization SHALL start on v1->v2 at row y0.
REQ-020 When y0 == y2 (all rows equal), SHALL emit one span at row y0, from min to max of x0,x1,x2.
REQ-021 STEP: SHALL advance both edges to the current row, taking one cycle per DDA increment; the cycle count is unbounded by the spec but finite.
REQ-022 EMIT: span_xl/span_xr SHALL be the min/max of the two edge x values; span_start pulses for exactly one cycle.
REQ-023 Rows with y < 0 or y >= FB_HEIGHT SHALL be skipped with no span_start; DDA state still advances.
REQ-024 Spans with span_xl >= FB_WIDTH or span_xr < 0 SHALL be skipped with no span_start, because the drawer would never leave its idle state.
REQ-025 Partially off-screen spans SHALL be emitted unclipped; horizontal clipping belongs to the span drawer.
REQ-026 WAIT1: SHALL ignore span_busy_in for the one cycle after span_start.
REQ-027 WAIT: SHALL remain until span_busy_in == 0, then go to STEP for row+1, or to FIN after row y2.
REQ-028 FIN: done SHALL pulse one cycle, busy SHALL drop in the same cycle, and the FSM SHALL return to IDLE.
REQ-029 span_y/xl/xr SHALL hold stable from span_start until the next EMIT.
REQ-030 Internal DDA products/errors SHALL use at least 2*COORD_WIDTH+1 bits, with no overflow for any COORD_WIDTH input.

Reset
REQ-031 rst_in high SHALL immediately force IDLE; busy, done and span_start go to 0; span_y, span_xl and span_xr go to 0.
REQ-032 Reset mid-operation SHALL abandon the triangle with no further span_start or done; after release the block SHALL accept a new start.

Verification
REQ-033 Triangle (0,0),(4,2),(0,4), drawer busy 3 cycles per span -> spans y0[0,0], y1[0,2], y2[0,4], y3[0,2], y4[0,0], then a single done.
REQ-034 Same vertices given in the order (0,4),(0,0),(4,2) -> the identical span sequence.
REQ-035 Flat top (0,10),(8,10),(4,14) -> y10[0,8] … y14[4,4]; five spans total.
REQ-036 Triangle (-20,-5),(400,-5),(100,3) -> rows -5..-1 are skipped, then spans for rows 0..3 only.
REQ-037 Degenerate (5,7),(2,7),(9,7) -> one span y7[2,9], then done.
REQ-038 rst_in pulsed while in WAIT mid-triangle -> outputs 0 at once and no done; a new start then completes normally.
